// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: default widths, frame limit and the
// write-side state type used by the frame FIFO.
package eth_pkg;

  localparam int unsigned ETH_DATA_W    = 32;
  localparam int unsigned ETH_MAX_WORDS = 375;

  typedef enum logic [1:0] {
    WrIdle,
    WrFrame,
    WrDrop
  } wr_state_e;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module eth_sdp_ram #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: frames become readable only once their
// tlast beat is written; oversize or non-fitting frames are discarded whole.
module eth_tx_frame_fifo
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W    = ETH_DATA_W,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MAX_WORDS = ETH_MAX_WORDS
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   frame_cnt,
  output logic              drop_pulse
);

  localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned RAM_W = DATA_W + 1;

  typedef logic [ADDR_W-1:0] ptr_t;

  wr_state_e        state_q, state_d;
  ptr_t             wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  ptr_t             used;
  logic [LEN_W-1:0] wr_len_q, wr_len_d;
  logic [ADDR_W:0]  frame_cnt_q, frame_cnt_d;
  logic             ready_q, drop_q, drop_d;
  logic             accept, commit, full, too_long;
  logic             ram_we, ram_re, ram_vld_q;
  logic [RAM_W-1:0] ram_rdata;
  logic             pf_vld_q, pf_vld_d, out_vld_q, out_vld_d;
  logic [RAM_W-1:0] pf_q, pf_d, out_q, out_d;
  logic             pop, pop_last;
  logic [1:0]       occ;

  eth_sdp_ram #(
    .WIDTH  (RAM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Write side: used words include the uncommitted part of the current frame.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_len_d    = wr_len_q;
    drop_d      = 1'b0;
    ram_we      = 1'b0;
    commit      = 1'b0;
    accept      = s_axis_tvalid & ready_q;
    used        = wr_ptr_q - rd_ptr_q;
    full        = (used == '1);
    too_long    = (wr_len_q >= LEN_W'(MAX_WORDS));
    unique case (state_q)
      WrIdle, WrFrame: begin
        if (accept) begin
          if (full || too_long) begin
            wr_ptr_d = wr_commit_q;
            wr_len_d = '0;
            drop_d   = 1'b1;
            state_d  = s_axis_tlast ? WrIdle : WrDrop;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (s_axis_tlast) begin
              commit      = 1'b1;
              wr_commit_d = wr_ptr_q + ptr_t'(1);
              wr_len_d    = '0;
              state_d     = WrIdle;
            end else begin
              wr_len_d = wr_len_q + LEN_W'(1);
              state_d  = WrFrame;
            end
          end
        end
      end
      WrDrop: begin
        if (accept && s_axis_tlast) state_d = WrIdle;
      end
      default: state_d = WrIdle;
    endcase
  end

  // Read side: a RAM read is issued only if its data is certain to find a
  // free slot in the prefetch/output pair when it lands a cycle later.
  always_comb begin
    pop       = out_vld_q & m_axis_tready;
    pop_last  = pop & out_q[DATA_W];
    occ       = {1'b0, out_vld_q} + {1'b0, pf_vld_q} + {1'b0, ram_vld_q} - {1'b0, pop};
    ram_re    = (rd_ptr_q != wr_commit_q) && (occ <= 2'd1);
    rd_ptr_d  = ram_re ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    pf_d      = pf_q;
    pf_vld_d  = pf_vld_q;
    if (!out_vld_q || pop) begin
      if (pf_vld_q) begin
        out_d     = pf_q;
        out_vld_d = 1'b1;
        pf_d      = ram_rdata;
        pf_vld_d  = ram_vld_q;
      end else if (ram_vld_q) begin
        out_d     = ram_rdata;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (ram_vld_q) begin
      pf_d     = ram_rdata;
      pf_vld_d = 1'b1;
    end
    unique case ({commit, pop_last})
      2'b10:   frame_cnt_d = frame_cnt_q + (ADDR_W + 1)'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - (ADDR_W + 1)'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= WrIdle;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      wr_len_q    <= '0;
      frame_cnt_q <= '0;
      ready_q     <= 1'b0;
      drop_q      <= 1'b0;
      ram_vld_q   <= 1'b0;
      pf_vld_q    <= 1'b0;
      pf_q        <= '0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_len_q    <= wr_len_d;
      frame_cnt_q <= frame_cnt_d;
      ready_q     <= 1'b1;
      drop_q      <= drop_d;
      ram_vld_q   <= ram_re;
      pf_vld_q    <= pf_vld_d;
      pf_q        <= pf_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = out_q[DATA_W-1:0];
  assign m_axis_tlast  = out_q[DATA_W];
  assign m_axis_tvalid = out_vld_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Bench for eth_tx_frame_fifo: directed scenarios with random payloads, checked
// against a frame-level model (accepted frames queued word by word).
module tb_eth_tx_frame_fifo;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 9;
  localparam int unsigned MW  = 375;
  localparam int unsigned CAP = 511;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [AW:0]   frame_cnt;
  logic          drop_pulse;

  always #5 aclk = ~aclk;

  eth_tx_frame_fifo #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MAX_WORDS (MW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt),
    .drop_pulse    (drop_pulse)
  );

  int          checks = 0;
  int          errors = 0;
  int          drops = 0;
  int          exp_drops = 0;
  int          ready_mode = 1;  // 0: held low, 1: held high, 2: random
  logic [DW:0] exp_q[$];
  logic [DW-1:0] frm[$];
  logic        in_frame = 1'b0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!aresetn) begin
      in_frame   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (s_axis_tvalid) check("s_tready", 64'(s_axis_tready), 64'd1);
      if (drop_pulse) drops++;
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_beat));
      end
      if (in_frame) check("valid_mid_frame", 64'(m_axis_tvalid), 64'd1);
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        assert (exp_q.size() != 0)
        else begin
          errors++;
          $error("FAIL beat_unexpected: observed=0x%0h expected=none",
                 {m_axis_tlast, m_axis_tdata});
        end
        if (exp_q.size() != 0) begin
          check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
          in_frame = !m_axis_tlast;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Send frm back-to-back, then apply the model: a frame is delivered iff it is
  // within the length limit and fits in the space not held by undelivered words.
  task automatic send_frm();
    int len;
    len = frm.size();
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm[i];
      s_axis_tlast  = (i == len - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (len <= int'(MW) && len <= int'(CAP) - exp_q.size()) begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), frm[i]});
    end else begin
      exp_drops++;
    end
  endtask

  task automatic rand_frm(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back($urandom);
  endtask

  task automatic drain(input int budget, output int gaps);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    gaps = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
      if (m_axis_tvalid) seen = 1'b1;
      else if (seen && exp_q.size() != 0) gaps++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gaps;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_drop", 64'(drop_pulse), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    aresetn = 1'b1;
    tick();
    check("s_tready_up", 64'(s_axis_tready), 64'd1);

    // Single 4-word frame with known payload.
    frm = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_frm();
    check("fc_after_commit", 64'(frame_cnt), 64'd1);
    lat = 0;
    while (!m_axis_tvalid && lat < 3) begin
      tick();
      lat++;
    end
    check("first_beat_within_3", 64'(m_axis_tvalid), 64'd1);
    drain(100, gaps);
    check("fc_4w_drained", 64'(frame_cnt), 64'd0);

    // 100 random 256-word frames, sink always ready.
    for (int f = 0; f < 100; f++) begin
      rand_frm(256);
      send_frm();
    end
    drain(2000, gaps);
    check("fc_256w_drained", 64'(frame_cnt), 64'd0);
    check("drops_256w", 64'(drops), 64'(exp_drops));

    // Oversize frame dropped, following short frame kept.
    rand_frm(376);
    send_frm();
    rand_frm(8);
    send_frm();
    drain(200, gaps);
    check("drops_oversize", 64'(drops), 64'(exp_drops));
    check("fc_oversize", 64'(frame_cnt), 64'd0);

    // Sink stalled: third 200-word frame cannot fit.
    ready_mode = 0;
    tick();
    for (int f = 0; f < 3; f++) begin
      rand_frm(200);
      send_frm();
    end
    repeat (4) tick();
    check("fc_full", 64'(frame_cnt), 64'd2);
    check("drops_full", 64'(drops), 64'(exp_drops));
    ready_mode = 1;
    drain(1000, gaps);
    check("back_to_back_gaps", 64'(gaps), 64'd0);
    check("fc_full_drained", 64'(frame_cnt), 64'd0);

    // Random sink backpressure on 1- and 3-word frames.
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      rand_frm(($urandom_range(0, 1) != 0) ? 3 : 1);
      send_frm();
    end
    drain(2000, gaps);
    ready_mode = 1;
    tick();
    check("fc_short_drained", 64'(frame_cnt), 64'd0);
    check("drops_short", 64'(drops), 64'(exp_drops));

    // Reset in the middle of output discards everything buffered.
    rand_frm(50);
    send_frm();
    repeat (10) tick();
    check("mid_output_valid", 64'(m_axis_tvalid), 64'd1);
    aresetn = 1'b0;
    tick();
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    aresetn = 1'b1;
    exp_q.delete();
    tick();
    rand_frm(4);
    send_frm();
    drain(100, gaps);
    check("fc_after_reset", 64'(frame_cnt), 64'd0);
    check("idle_after_reset", 64'(m_axis_tvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_fifo.md
ETH_TX_FRAME_FIFO -- requirements
Module: eth_tx_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI-Stream data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, buffer address width, giving 512 words.
REQ-003 SHALL have parameter MAX_WORDS, default 375, maximum words per frame (1500 bytes).
REQ-004 SHALL have port aclk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tlast, inputs, DATA_W/1/1, frame source.
REQ-007 SHALL have port s_axis_tready, output, 1, input accept.
REQ-008 SHALL have ports m_axis_tdata/tvalid/tlast, outputs, DATA_W/1/1, feed to eth_tx s_axis.
REQ-009 SHALL have port m_axis_tready, input, 1, eth_tx ready.
REQ-010 SHALL have port frame_cnt, output, ADDR_W+1, committed frames not yet fully read.
REQ-011 SHALL have port drop_pulse, output, 1, one-cycle pulse per discarded frame.

Function
REQ-012 SHALL be store-and-forward: no word of a frame appears on m_axis before its tlast beat is accepted on s_axis.
REQ-013 SHALL store tlast with each word (RAM width DATA_W+1).
REQ-014 SHALL hold s_axis_tready=1 whenever out of reset; no input backpressure.
REQ-015 Write states: WR_IDLE, WR_FRAME, WR_DROP; a beat accepted in WR_IDLE without tlast enters WR_FRAME; a tlast beat returns to WR_IDLE.
REQ-016 Each accepted beat in WR_IDLE/WR_FRAME SHALL be written at wr_ptr, and wr_ptr SHALL then increment modulo 2^ADDR_W.
REQ-017 On accepted tlast beat, wr_commit SHALL take the post-write wr_ptr and frame_cnt SHALL increment.
REQ-018 Overflow SHALL be a beat arriving while used words (wr_ptr-rd_ptr, modulo, uncommitted included) equal 2^ADDR_W-1, or a beat that would be word MAX_WORDS+1 of the frame.
REQ-019 On overflow the beat SHALL NOT be written, wr_ptr SHALL rewind to wr_commit next cycle, and drop_pulse SHALL assert for one cycle; without tlast the FSM SHALL enter WR_DROP, with tlast it SHALL enter WR_IDLE.
REQ-020 WR_DROP SHALL discard all beats until tlast, then return to WR_IDLE with no further pulse.
REQ-021 Read side SHALL use synchronous RAM read (1 cycle) plus a prefetch/output register pair to sustain 1 word/cycle.
REQ-022 Read SHALL start only when frame_cnt>0 or a frame is in progress; once a frame's first beat is valid, m_axis_tvalid SHALL stay high through its tlast beat.
REQ-023 m_axis_tdata/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-024 First beat SHALL be valid at most 3 cycles after commit with the output stage empty.
REQ-025 frame_cnt SHALL decrement on m_axis tlast handshake; simultaneous commit and tlast handshake SHALL leave it unchanged.
REQ-026 Single-word frames (tlast on first beat) SHALL be supported in both directions.
REQ-027 Back-to-back frames SHALL be output with no idle cycle between tlast and the next first beat when the next frame is committed.

Reset
REQ-028 While aresetn=0 at a clock edge: wr_ptr, wr_commit, rd_ptr, frame_cnt=0; FSM=WR_IDLE; m_axis_tvalid, m_axis_tlast, drop_pulse, s_axis_tready=0; m_axis_tdata=0.
REQ-029 Reset mid-frame on either side SHALL discard all buffered data; RAM contents need not be cleared.

Structure
REQ-030 DATA_W, the FSM state enum and MAX_WORDS SHALL reside in the shared eth package.
REQ-031 RAM SHALL be a sub-module eth_sdp_ram (simple dual-port, one write, one synchronous read port).

Verification
REQ-032 One 4-word frame 0x11111111..0x44444444, tready=1 -> identical 4 beats with tlast on 4th, first beat <=3 cycles after input tlast, frame_cnt 1->0.
REQ-033 100 frames of 256 random words, tready held 1 -> output bit-exact, tvalid never drops mid-frame, drop_pulse never asserted.
REQ-034 376-word frame then 8-word frame -> one drop_pulse, only 8-word frame output.
REQ-035 tready=0, three 200-word frames -> frames 1 and 2 stored, frame 3 dropped (capacity 511), frame_cnt=2; then tready=1 -> both frames output intact.
REQ-036 Random tready toggling (50%) on 1-word and 3-word frames -> data held stable while stalled, order preserved.
REQ-037 aresetn=0 for 1 cycle mid-output -> next cycle m_axis_tvalid=0, frame_cnt=0; subsequent 4-word frame passes correctly.
